// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter owner and single-outstanding instruction fetcher
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   BrTaken, Jump, Target       redirect request from branch comparator / execute
//   Stall                       downstream not ready; hold the current instruction
//   imem_req, imem_addr         one-cycle fetch request and its address
//   imem_rvalid, imem_rdata     fetch response
//   inst_valid, inst, inst_pc   held instruction presented to decode
//   pc_plus4                    inst_pc + 4 (link value)
//   misalign                    one-cycle pulse after a redirect to an unaligned target
//   fetch_err                   sticky fetch timeout flag
//   instret                     retired-instruction counter
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BrTaken,
    input  logic             Jump,
    input  logic [31:0]      Target,
    input  logic             Stall,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    output logic [31:0]      pc_plus4,
    output logic             misalign,
    output logic             fetch_err,
    output logic [CNT_W-1:0] instret
);
    localparam int WC_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, ERR} state_t;

    state_t          state, state_nxt;
    logic [31:0]     pc;
    logic [31:0]     next_pc;
    logic [WC_W-1:0] wait_cnt;
    logic            retire;
    logic            redirect;
    logic            timeout;

    assign pc_plus4 = inst_pc + 32'd4;
    assign retire   = (state == HOLD) && !Stall;
    assign redirect = BrTaken | Jump;
    assign next_pc  = redirect ? {Target[31:2], 2'b00} : pc_plus4;
    assign timeout  = wait_cnt == WC_W'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ISSUE;
        else
            state <= state_nxt;
    end

    // A response arriving on the timeout cycle still wins over the error.
    always_comb begin
        state_nxt = state;
        case (state)
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = imem_rvalid ? HOLD : (timeout ? ERR : WAIT);
            HOLD:    state_nxt = Stall ? HOLD : ISSUE;
            default: state_nxt = ERR;
        endcase
    end

    always_comb begin
        imem_req   = state == ISSUE;
        imem_addr  = pc;
        inst_valid = state == HOLD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            inst      <= 32'h0000_0013;
            inst_pc   <= RESET_PC;
            wait_cnt  <= '0;
            misalign  <= 1'b0;
            fetch_err <= 1'b0;
            instret   <= '0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + WC_W'(1) : '0;
            if (state == WAIT && imem_rvalid) begin
                inst    <= imem_rdata;
                inst_pc <= pc;
            end
            if (retire) begin
                pc      <= next_pc;
                instret <= instret + CNT_W'(1);
            end
            misalign <= retire && redirect && (Target[1:0] != 2'b00);
            if (state_nxt == ERR)
                fetch_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        BrTaken = 1'b0;
    logic        Jump = 1'b0;
    logic [31:0] Target = '0;
    logic        Stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic        fetch_err;
    logic [31:0] instret;

    int          n_chk = 0;
    int          n_fail = 0;
    int          mis_cnt = 0;
    bit          mem_en = 1'b1;
    bit          pend = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] req_log[$];
    logic [31:0] hold_pc;
    logic [31:0] s_inst, s_pc, s_ret;
    int          s_req;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .BrTaken(BrTaken), .Jump(Jump), .Target(Target),
        .Stall(Stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst(inst), .inst_pc(inst_pc), .pc_plus4(pc_plus4), .misalign(misalign),
        .fetch_err(fetch_err), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic log_req;
        pend  = imem_req;
        paddr = imem_addr;
        if (imem_req) req_log.push_back(imem_addr);
    endtask

    // Memory model with latency 1: answers in the cycle after the request.
    task automatic tick;
        @(posedge clk);
        #1;
        mis_cnt += int'(misalign);
        if (mem_en) begin
            imem_rvalid = pend;
            imem_rdata  = memw(paddr);
        end
        log_req();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        imem_rvalid = 1'b0;
        BrTaken = 1'b0;
        Jump = 1'b0;
        Target = '0;
        Stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        log_req();
    endtask

    task automatic fetch_one(input logic br, input logic jmp, input logic [31:0] tgt);
        BrTaken = br;
        Jump = jmp;
        Target = tgt;
        tick();
        tick();
        hold_pc = inst_pc;
        tick();
        BrTaken = 1'b0;
        Jump = 1'b0;
        Target = '0;
    endtask

    initial begin
        // 1) sequential fetch
        do_reset();
        check("rst_req", imem_req, 1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", inst_valid, 0);
        check("rst_instret", instret, 0);
        check("rst_err", fetch_err, 0);
        check("rst_mis", misalign, 0);
        check("rst_inst", inst, 32'h13);
        tick();
        tick();
        check("hold_valid", inst_valid, 1);
        check("hold_pc0", inst_pc, 32'h0);
        check("pc_plus4", pc_plus4, 32'h4);
        check("hold_inst", inst, memw(32'h0));
        repeat (7) tick();
        check("instret3", instret, 3);
        check("req_cnt", req_log.size(), 4);
        check("addr0", req_log[0], 32'h0);
        check("addr1", req_log[1], 32'h4);
        check("addr2", req_log[2], 32'h8);
        // 2) branch taken / not taken from inst_pc 0x10
        fetch_one(1'b0, 1'b0, 32'h0);
        check("seq_0x10", imem_addr, 32'h10);
        fetch_one(1'b1, 1'b0, 32'h40);
        check("br_hold_pc", hold_pc, 32'h10);
        check("br_taken", imem_addr, 32'h40);
        fetch_one(1'b0, 1'b1, 32'h10);
        check("jmp_back", imem_addr, 32'h10);
        fetch_one(1'b0, 1'b0, 32'h40);
        check("nt_hold_pc", hold_pc, 32'h10);
        check("br_not_taken", imem_addr, 32'h14);
        check("no_mis", mis_cnt, 0);
        // 3) misaligned jump
        fetch_one(1'b0, 1'b1, 32'h82);
        check("mis_addr", imem_addr, 32'h80);
        check("mis_pulse", misalign, 1);
        tick();
        check("mis_clear", misalign, 0);
        check("mis_once", mis_cnt, 1);
        // 4) stall in HOLD, redirect inputs ignored while stalled
        Stall = 1'b1;
        tick();
        s_inst = inst;
        s_pc = inst_pc;
        s_ret = instret;
        s_req = req_log.size();
        check("stall_ret", instret, 8);
        check("stall_pc", inst_pc, 32'h80);
        BrTaken = 1'b1;
        Target = 32'h200;
        repeat (5) tick();
        check("stall_valid", inst_valid, 1);
        check("stall_inst", inst, s_inst);
        check("stall_ipc", inst_pc, s_pc);
        check("stall_cnt", instret, s_ret);
        check("stall_noreq", req_log.size(), s_req);
        Stall = 1'b0;
        BrTaken = 1'b0;
        Target = '0;
        tick();
        check("rel_ret", instret, 9);
        check("rel_req", imem_req, 1);
        check("rel_addr", imem_addr, 32'h84);
        check("rel_valid", inst_valid, 0);
        check("mis_total", mis_cnt, 1);
        // 5a) timeout after 16 WAIT cycles
        mem_en = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        repeat (15) tick();
        check("to_16_err", fetch_err, 0);
        check("to_16_valid", inst_valid, 0);
        tick();
        check("to_err", fetch_err, 1);
        check("to_noreq", imem_req, 0);
        s_req = req_log.size();
        imem_rvalid = 1'b1;
        repeat (3) tick();
        imem_rvalid = 1'b0;
        check("err_sticky", fetch_err, 1);
        check("err_valid", inst_valid, 0);
        check("err_noreq", req_log.size(), s_req);
        check("err_ret", instret, 9);
        // 5b) response on the 16th WAIT cycle wins
        do_reset();
        check("rst2_err", fetch_err, 0);
        tick();
        repeat (15) tick();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hCAFE_0013;
        tick();
        imem_rvalid = 1'b0;
        check("late_valid", inst_valid, 1);
        check("late_err", fetch_err, 0);
        check("late_inst", inst, 32'hCAFE_0013);
        check("late_pc", inst_pc, 32'h0);
        // 6) reset during WAIT, stale response right after reset
        tick();
        check("r6_ret", instret, 1);
        check("r6_addr", imem_addr, 32'h4);
        tick();
        rst = 1'b1;
        #1;
        check("async_ret", instret, 0);
        check("async_valid", inst_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0BAD_0BAD;
        #1;
        check("r6_req", imem_req, 1);
        check("r6_pc", imem_addr, 32'h0);
        tick();
        imem_rvalid = 1'b0;
        tick();
        check("stale_valid", inst_valid, 0);
        check("stale_inst", inst, 32'h13);
        check("stale_ret", instret, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
